// File: rtl/data_mem_responder_pkg.sv
// Shared definitions for the data-memory responder and the CPU control path:
// load-mode encodings, FSM states and the wait-state legality rule.
package data_mem_responder_pkg;

  localparam logic [1:0] LB_WORD  = 2'b00;
  localparam logic [1:0] LB_SBYTE = 2'b01;
  localparam logic [1:0] LB_UBYTE = 2'b10;
  localparam logic [1:0] LB_RSVD  = 2'b11;

  localparam int unsigned LATENCY_MIN = 1;
  localparam int unsigned LATENCY_MAX = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic latency_legal(input int unsigned lat);
    return (lat >= LATENCY_MIN) && (lat <= LATENCY_MAX);
  endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Core-to-data-memory request/acknowledge bus; the core is the master.
interface data_mem_responder_if;

  logic        req;
  logic        we;
  logic        wr_byte;
  logic [1:0]  load_byte;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        ack;
  logic        busy;
  logic        err;

  modport master (
    output req, we, wr_byte, load_byte, addr, wdata,
    input  rdata, ack, busy, err
  );

  modport slave (
    input  req, we, wr_byte, load_byte, addr, wdata,
    output rdata, ack, busy, err
  );

endinterface

// File: rtl/data_mem_responder_load_extend.sv
// Byte-lane select plus sign/zero extension of a loaded word; reused by the
// stall-capable datapath.
module load_extend
  import data_mem_responder_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  load_byte_i,
  output logic [31:0] data_o
);

  logic [7:0] lane_byte;

  // little-endian lane pick: lane 0 is bits 7:0
  always_comb begin
    lane_byte = word_i[7:0];
    case (lane_i)
      2'd0:    lane_byte = word_i[7:0];
      2'd1:    lane_byte = word_i[15:8];
      2'd2:    lane_byte = word_i[23:16];
      2'd3:    lane_byte = word_i[31:24];
      default: lane_byte = word_i[7:0];
    endcase
  end

  always_comb begin
    data_o = 32'h0000_0000;
    case (load_byte_i)
      LB_WORD:  data_o = word_i;
      LB_SBYTE: data_o = {{24{lane_byte[7]}}, lane_byte};
      LB_UBYTE: data_o = {24'h00_0000, lane_byte};
      default:  data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Multi-cycle data-memory responder: accepts one load/store at a time, waits
// LATENCY cycles, commits the access and pulses ack with data/error status.
module data_mem_responder
  import data_mem_responder_pkg::*;
#(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned LATENCY = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  data_mem_responder_if.slave  bus
);

  if (!latency_legal(LATENCY)) begin : g_latency_check
    $error("data_mem_responder: LATENCY must be within 1..15");
  end

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [31:0] mem_q [DEPTH];

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic        ack_q, ack_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic        we_q;
  logic        wr_byte_q;
  logic [1:0]  lb_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;

  logic              accept;
  logic              commit;
  logic              word_access;
  logic              access_err;
  logic              mem_we;
  logic [ADDR_W-1:0] widx;
  logic [31:0]       rd_word;
  logic [31:0]       mem_wdata;
  logic [31:0]       ext_data;

  assign widx    = addr_q[ADDR_W+1:2];
  assign rd_word = mem_q[widx];

  assign word_access = we_q ? !wr_byte_q : (lb_q == LB_WORD);
  assign access_err  = (word_access && (addr_q[1:0] != 2'b00))
                     || ((addr_q >> (ADDR_W + 2)) != 32'd0)
                     || (!we_q && (lb_q == LB_RSVD));
  assign mem_we      = commit && we_q && !access_err;

  load_extend u_load_extend (
    .word_i      (rd_word),
    .lane_i      (addr_q[1:0]),
    .load_byte_i (lb_q),
    .data_o      (ext_data)
  );

  // read-modify-write merge so a byte store leaves the other lanes intact
  always_comb begin
    mem_wdata = wdata_q;
    if (wr_byte_q) begin
      mem_wdata = rd_word;
      case (addr_q[1:0])
        2'd0:    mem_wdata[7:0]   = wdata_q[7:0];
        2'd1:    mem_wdata[15:8]  = wdata_q[7:0];
        2'd2:    mem_wdata[23:16] = wdata_q[7:0];
        2'd3:    mem_wdata[31:24] = wdata_q[7:0];
        default: mem_wdata[7:0]   = wdata_q[7:0];
      endcase
    end else begin
      mem_wdata = wdata_q;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;
    busy_d  = busy_q;
    err_d   = err_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          accept  = 1'b1;
          cnt_d   = 4'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          commit  = 1'b1;
          ack_d   = 1'b1;
          err_d   = access_err;
          rdata_d = (access_err || we_q) ? 32'h0000_0000 : ext_data;
          state_d = RESP;
        end
      end
      RESP: begin
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'h0000_0000;
        state_d = IDLE;
      end
      default: begin
        cnt_d   = 4'd0;
        ack_d   = 1'b0;
        busy_d  = 1'b0;
        err_d   = 1'b0;
        rdata_d = 32'h0000_0000;
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, wait counter and registered response outputs
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0000_0000;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // request fields are frozen at acceptance
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      we_q      <= 1'b0;
      wr_byte_q <= 1'b0;
      lb_q      <= LB_WORD;
      addr_q    <= 32'h0000_0000;
      wdata_q   <= 32'h0000_0000;
    end else if (accept) begin
      we_q      <= bus.we;
      wr_byte_q <= bus.wr_byte;
      lb_q      <= bus.load_byte;
      addr_q    <= bus.addr;
      wdata_q   <= bus.wdata;
    end
  end

  // RAM array; reset on the commit edge suppresses the write
  always_ff @(posedge clk_i) begin
    if (rst_ni && mem_we) begin
      mem_q[widx] <= mem_wdata;
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule
